// File: rtl/gen_active_vertex_edge_req.sv
// gen_active_vertex_edge_req
// Buffers incoming active vertices and expands each one into a stream of
// edge-memory read requests covering the half-open range [start, end).
// Forwards the upstream iteration-end token once the block is fully drained.

`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef V_VALUE_WIDTH
`define V_VALUE_WIDTH 32
`endif
`ifndef V_OFF_DWIDTH
`define V_OFF_DWIDTH 64
`endif

module gen_active_vertex_edge_req #(
    parameter int V_ID_WIDTH    = `V_ID_WIDTH,
    parameter int V_VALUE_WIDTH = `V_VALUE_WIDTH,
    parameter int V_OFF_DWIDTH  = `V_OFF_DWIDTH,
    parameter int BUF_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      front_push_flag,
    input  logic [V_ID_WIDTH-1:0]     front_active_v_id,
    input  logic [V_VALUE_WIDTH-1:0]  front_active_v_value,
    input  logic                      front_active_v_pull_first_flag,
    input  logic [V_OFF_DWIDTH-1:0]   front_active_v_offset,
    input  logic                      front_active_v_id_valid,
    input  logic                      front_iteration_end,
    input  logic                      front_iteration_end_valid,
    input  logic                      next_stage_full,
    output logic                      stage_full,
    output logic                      push_flag,
    output logic [V_ID_WIDTH-1:0]     active_v_id,
    output logic [V_VALUE_WIDTH-1:0]  active_v_value,
    output logic                      active_v_pull_first_flag,
    output logic [V_OFF_DWIDTH/2-1:0] rd_edge_addr,
    output logic                      rd_edge_last,
    output logic                      rd_edge_valid,
    output logic                      iteration_end,
    output logic                      iteration_end_valid,
    output logic                      overflow
);

    localparam int E_AWIDTH = V_OFF_DWIDTH / 2;
    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(BUF_DEPTH);
    // Four entries of slack cover the upstream reaction delay to stage_full.
    localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(BUF_DEPTH - 4);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    // One buffered vertex; the offset word is {end, start}.
    typedef struct packed {
        logic                     push;
        logic [V_ID_WIDTH-1:0]    id;
        logic [V_VALUE_WIDTH-1:0] value;
        logic                     pull_first;
        logic [E_AWIDTH-1:0]      off_end;
        logic [E_AWIDTH-1:0]      off_start;
    } vertex_t;

    vertex_t mem_q [BUF_DEPTH];
    vertex_t wr_entry;
    vertex_t head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    logic [0:0]          state_q, state_d;
    logic [E_AWIDTH-1:0] cur_q, cur_d;
    logic [E_AWIDTH-1:0] end_q, end_d;
    logic [E_AWIDTH-1:0] cur_inc;

    logic                     v_push_q, v_push_d;
    logic [V_ID_WIDTH-1:0]    v_id_q, v_id_d;
    logic [V_VALUE_WIDTH-1:0] v_value_q, v_value_d;
    logic                     v_pf_q, v_pf_d;

    logic                     rd_valid_q, rd_valid_d;
    logic                     rd_last_q, rd_last_d;
    logic [E_AWIDTH-1:0]      rd_addr_q, rd_addr_d;
    logic                     o_push_q, o_push_d;
    logic [V_ID_WIDTH-1:0]    o_id_q, o_id_d;
    logic [V_VALUE_WIDTH-1:0] o_value_q, o_value_d;
    logic                     o_pf_q, o_pf_d;
    logic                     iter_end_q, iter_end_d;

    assign head    = mem_q[rd_ptr_q];
    // Increment stays in E_AWIDTH bits; an end of 2^E_AWIDTH-1 is reached
    // before any wrap can occur because start < end is required to issue.
    assign cur_inc = cur_q + E_AWIDTH'(1);

    // Pack the incoming vertex into a buffer entry.
    always_comb begin
        wr_entry.push       = front_push_flag;
        wr_entry.id         = front_active_v_id;
        wr_entry.value      = front_active_v_value;
        wr_entry.pull_first = front_active_v_pull_first_flag;
        wr_entry.off_end    = front_active_v_offset[2*E_AWIDTH-1:E_AWIDTH];
        wr_entry.off_start  = front_active_v_offset[E_AWIDTH-1:0];
    end

    // Edge-issue FSM: pop a vertex in IDLE, walk its edge range in ISSUE.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        v_push_d   = v_push_q;
        v_id_d     = v_id_q;
        v_value_d  = v_value_q;
        v_pf_d     = v_pf_q;
        rd_valid_d = 1'b0;
        rd_last_d  = rd_last_q;
        rd_addr_d  = rd_addr_q;
        o_push_d   = o_push_q;
        o_id_d     = o_id_q;
        o_value_d  = o_value_q;
        o_pf_d     = o_pf_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    v_push_d  = head.push;
                    v_id_d    = head.id;
                    v_value_d = head.value;
                    v_pf_d    = head.pull_first;
                    cur_d     = head.off_start;
                    end_d     = head.off_end;
                    // Zero-degree or malformed ranges are dropped here.
                    if (head.off_start < head.off_end) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!next_stage_full) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = cur_q;
                    rd_last_d  = (cur_inc == end_q);
                    o_push_d   = v_push_q;
                    o_id_d     = v_id_q;
                    o_value_d  = v_value_q;
                    o_pf_d     = v_pf_q;
                    cur_d      = cur_inc;
                    if (cur_inc == end_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer bookkeeping: a write into a full buffer succeeds only alongside a pop.
    always_comb begin
        push       = front_active_v_id_valid && ((count_q != DEPTH_CNT) || pop);
        overflow_d = overflow_q ||
                     (front_active_v_id_valid && (count_q == DEPTH_CNT) && !pop);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        iter_end_d = front_iteration_end && front_iteration_end_valid &&
                     (count_q == '0) && (state_q == S_IDLE) &&
                     !front_active_v_id_valid;
    end

    // Buffer storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the reset pointers make stale entries unreachable.
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cur_q      <= '0;
            end_q      <= '0;
            v_push_q   <= 1'b0;
            v_id_q     <= '0;
            v_value_q  <= '0;
            v_pf_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_addr_q  <= '0;
            o_push_q   <= 1'b0;
            o_id_q     <= '0;
            o_value_q  <= '0;
            o_pf_q     <= 1'b0;
            iter_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cur_q      <= cur_d;
            end_q      <= end_d;
            v_push_q   <= v_push_d;
            v_id_q     <= v_id_d;
            v_value_q  <= v_value_d;
            v_pf_q     <= v_pf_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_addr_q  <= rd_addr_d;
            o_push_q   <= o_push_d;
            o_id_q     <= o_id_d;
            o_value_q  <= o_value_d;
            o_pf_q     <= o_pf_d;
            iter_end_q <= iter_end_d;
        end
    end

    assign stage_full               = (count_q >= FULL_THRESH);
    assign overflow                 = overflow_q;
    assign rd_edge_valid            = rd_valid_q;
    assign rd_edge_last             = rd_last_q;
    assign rd_edge_addr             = rd_addr_q;
    assign push_flag                = o_push_q;
    assign active_v_id              = o_id_q;
    assign active_v_value           = o_value_q;
    assign active_v_pull_first_flag = o_pf_q;
    assign iteration_end            = iter_end_q;
    assign iteration_end_valid      = iter_end_q;

endmodule

// File: tb/tb_gen_active_vertex_edge_req.sv
// Directed bench for gen_active_vertex_edge_req. Inputs are driven and
// outputs sampled on the falling clock edge.

module tb_gen_active_vertex_edge_req;

    localparam int IDW   = 8;
    localparam int VALW  = 16;
    localparam int OFFW  = 16;
    localparam int EAW   = OFFW / 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            front_push_flag;
    logic [IDW-1:0]  front_active_v_id;
    logic [VALW-1:0] front_active_v_value;
    logic            front_active_v_pull_first_flag;
    logic [OFFW-1:0] front_active_v_offset;
    logic            front_active_v_id_valid;
    logic            front_iteration_end;
    logic            front_iteration_end_valid;
    logic            next_stage_full;
    logic            stage_full;
    logic            push_flag;
    logic [IDW-1:0]  active_v_id;
    logic [VALW-1:0] active_v_value;
    logic            active_v_pull_first_flag;
    logic [EAW-1:0]  rd_edge_addr;
    logic            rd_edge_last;
    logic            rd_edge_valid;
    logic            iteration_end;
    logic            iteration_end_valid;
    logic            overflow;

    int vectors     = 0;
    int miscompares = 0;
    int n_edges;
    int last_id;
    int seen;

    always #5 clk = ~clk;

    gen_active_vertex_edge_req #(
        .V_ID_WIDTH   (IDW),
        .V_VALUE_WIDTH(VALW),
        .V_OFF_DWIDTH (OFFW),
        .BUF_DEPTH    (DEPTH)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .front_push_flag               (front_push_flag),
        .front_active_v_id             (front_active_v_id),
        .front_active_v_value          (front_active_v_value),
        .front_active_v_pull_first_flag(front_active_v_pull_first_flag),
        .front_active_v_offset         (front_active_v_offset),
        .front_active_v_id_valid       (front_active_v_id_valid),
        .front_iteration_end           (front_iteration_end),
        .front_iteration_end_valid     (front_iteration_end_valid),
        .next_stage_full               (next_stage_full),
        .stage_full                    (stage_full),
        .push_flag                     (push_flag),
        .active_v_id                   (active_v_id),
        .active_v_value                (active_v_value),
        .active_v_pull_first_flag      (active_v_pull_first_flag),
        .rd_edge_addr                  (rd_edge_addr),
        .rd_edge_last                  (rd_edge_last),
        .rd_edge_valid                 (rd_edge_valid),
        .iteration_end                 (iteration_end),
        .iteration_end_valid           (iteration_end_valid),
        .overflow                      (overflow)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_vertex(input logic p, input logic [IDW-1:0] id,
                                input logic [VALW-1:0] val, input logic pf,
                                input logic [EAW-1:0] s, input logic [EAW-1:0] e);
        front_push_flag                = p;
        front_active_v_id              = id;
        front_active_v_value           = val;
        front_active_v_pull_first_flag = pf;
        front_active_v_offset          = {e, s};
        front_active_v_id_valid        = 1'b1;
    endtask

    task automatic exp_edge(input string tag, input int addr, input int last, input int id);
        chk({tag, "_valid"}, 32'(rd_edge_valid), 1);
        chk({tag, "_addr"}, 32'(rd_edge_addr), 32'(addr));
        chk({tag, "_last"}, 32'(rd_edge_last), 32'(last));
        chk({tag, "_id"}, 32'(active_v_id), 32'(id));
    endtask

    task automatic exp_none(input string tag);
        chk({tag, "_valid"}, 32'(rd_edge_valid), 0);
    endtask

    task automatic exp_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(rd_edge_valid), 0);
        chk({tag, "_addr"}, 32'(rd_edge_addr), 0);
        chk({tag, "_last"}, 32'(rd_edge_last), 0);
        chk({tag, "_id"}, 32'(active_v_id), 0);
        chk({tag, "_value"}, 32'(active_v_value), 0);
        chk({tag, "_push"}, 32'(push_flag), 0);
        chk({tag, "_pf"}, 32'(active_v_pull_first_flag), 0);
        chk({tag, "_sf"}, 32'(stage_full), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_ie"}, 32'(iteration_end), 0);
        chk({tag, "_iev"}, 32'(iteration_end_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                            = 1'b0;
        front_push_flag                = 1'b0;
        front_active_v_id              = '0;
        front_active_v_value           = '0;
        front_active_v_pull_first_flag = 1'b0;
        front_active_v_offset          = '0;
        front_active_v_id_valid        = 1'b0;
        front_iteration_end            = 1'b0;
        front_iteration_end_valid      = 1'b0;
        next_stage_full                = 1'b0;

        // Reset state
        repeat (3) cyc();
        exp_all_zero("rst");
        rst = 1'b1;
        cyc();
        exp_none("idle");

        // Single vertex id=5, edges [10,13): addr 10,11,12, last on 12
        drive_vertex(1'b1, 8'd5, 16'h1234, 1'b1, 8'd10, 8'd13);
        cyc();
        front_active_v_id_valid = 1'b0;
        exp_none("a_lat1");
        cyc();
        exp_none("a_lat2");
        cyc();
        exp_edge("a0", 10, 0, 5);
        chk("a0_value", 32'(active_v_value), 'h1234);
        chk("a0_push", 32'(push_flag), 1);
        chk("a0_pf", 32'(active_v_pull_first_flag), 1);
        cyc();
        exp_edge("a1", 11, 0, 5);
        cyc();
        exp_edge("a2", 12, 1, 5);
        cyc();
        exp_none("a_end");
        chk("a_hold_addr", 32'(rd_edge_addr), 12);

        // Zero-degree vertex [7,7) dropped, then [20,21) gives one last edge
        drive_vertex(1'b0, 8'd1, 16'h0001, 1'b0, 8'd7, 8'd7);
        cyc();
        drive_vertex(1'b0, 8'd2, 16'h0002, 1'b0, 8'd20, 8'd21);
        cyc();
        front_active_v_id_valid = 1'b0;
        exp_none("b_gap1");
        cyc();
        exp_none("b_gap2");
        cyc();
        exp_edge("b0", 20, 1, 2);
        chk("b0_push", 32'(push_flag), 0);
        cyc();
        exp_none("b_end1");
        cyc();
        exp_none("b_end2");

        // [0,4) with two stalled cycles after the first edge
        drive_vertex(1'b1, 8'd3, 16'h0333, 1'b0, 8'd0, 8'd4);
        cyc();
        front_active_v_id_valid = 1'b0;
        cyc();
        cyc();
        exp_edge("c0", 0, 0, 3);
        next_stage_full = 1'b1;
        cyc();
        exp_none("c_stall1");
        cyc();
        exp_none("c_stall2");
        next_stage_full = 1'b0;
        cyc();
        exp_edge("c1", 1, 0, 3);
        cyc();
        exp_edge("c2", 2, 0, 3);
        cyc();
        exp_edge("c3", 3, 1, 3);
        cyc();
        exp_none("c_end");

        // Top-of-range boundary [253,255) terminates without wrapping
        drive_vertex(1'b0, 8'd7, 16'h0777, 1'b1, 8'd253, 8'd255);
        cyc();
        front_active_v_id_valid = 1'b0;
        cyc();
        cyc();
        exp_edge("d0", 253, 0, 7);
        cyc();
        exp_edge("d1", 254, 1, 7);
        cyc();
        exp_none("d_end1");
        cyc();
        exp_none("d_end2");

        // Fill with the issuer stalled: stage_full at 12, overflow on 17th write
        next_stage_full = 1'b1;
        drive_vertex(1'b1, 8'hAA, 16'h00AA, 1'b0, 8'd0, 8'd2);
        cyc();
        front_active_v_id_valid = 1'b0;
        cyc();
        exp_none("e_blk_stall");
        for (int i = 1; i <= 17; i++) begin
            drive_vertex(1'b1, 8'(i), 16'(i), 1'b0, 8'd100, 8'd102);
            cyc();
            chk("e_sf", 32'(stage_full), 32'(((i > DEPTH) ? DEPTH : i) >= 12));
            chk("e_ovf", 32'(overflow), 32'(i == 17));
        end
        front_active_v_id_valid = 1'b0;
        next_stage_full = 1'b0;
        cyc();
        exp_edge("e_blk0", 0, 0, 'hAA);
        chk("e_ovf_sticky1", 32'(overflow), 1);
        chk("e_sf_full", 32'(stage_full), 1);
        cyc();
        exp_edge("e_blk1", 1, 1, 'hAA);
        // Write lands on the same cycle as a pop from the full buffer
        drive_vertex(1'b0, 8'h77, 16'h0077, 1'b0, 8'd50, 8'd51);
        cyc();
        front_active_v_id_valid = 1'b0;
        exp_none("e_bubble");
        chk("e_sf_pushpop", 32'(stage_full), 1);
        n_edges = 0;
        last_id = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (rd_edge_valid) begin
                n_edges++;
                last_id = int'(active_v_id);
            end
        end
        chk("e_edges", 32'(n_edges), 33);
        chk("e_last_id", 32'(last_id), 'h77);
        chk("e_sf_drained", 32'(stage_full), 0);
        chk("e_ovf_sticky2", 32'(overflow), 1);

        // Iteration-end token withheld until the buffer and issuer drain
        next_stage_full = 1'b1;
        drive_vertex(1'b0, 8'h21, 16'h0021, 1'b0, 8'd0, 8'd1);
        cyc();
        drive_vertex(1'b0, 8'h22, 16'h0022, 1'b0, 8'd0, 8'd1);
        cyc();
        front_active_v_id_valid   = 1'b0;
        front_iteration_end       = 1'b1;
        front_iteration_end_valid = 1'b1;
        cyc();
        chk("f_busy_ie1", 32'(iteration_end), 0);
        chk("f_busy_iev1", 32'(iteration_end_valid), 0);
        cyc();
        chk("f_busy_ie2", 32'(iteration_end), 0);
        next_stage_full = 1'b0;
        seen = 0;
        n_edges = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            cyc();
            if (rd_edge_valid) n_edges++;
            if (iteration_end) seen = 1;
        end
        chk("f_seen", 32'(seen), 1);
        chk("f_iev", 32'(iteration_end_valid), 1);
        chk("f_edges_before", 32'(n_edges), 2);
        front_iteration_end       = 1'b0;
        front_iteration_end_valid = 1'b0;
        cyc();
        chk("f_pulse_ie", 32'(iteration_end), 0);
        chk("f_pulse_iev", 32'(iteration_end_valid), 0);

        // Reset during issue of [0,8) abandons the vertex
        drive_vertex(1'b1, 8'd9, 16'h0999, 1'b1, 8'd0, 8'd8);
        cyc();
        front_active_v_id_valid = 1'b0;
        cyc();
        cyc();
        exp_edge("g0", 0, 0, 9);
        cyc();
        exp_edge("g1", 1, 0, 9);
        rst = 1'b0;
        cyc();
        exp_all_zero("g_rst");
        rst = 1'b1;
        cyc();
        exp_none("g_rel1");
        cyc();
        exp_none("g_rel2");
        drive_vertex(1'b0, 8'd4, 16'h0044, 1'b0, 8'd30, 8'd32);
        cyc();
        front_active_v_id_valid = 1'b0;
        cyc();
        cyc();
        exp_edge("g2", 30, 0, 4);
        chk("g2_value", 32'(active_v_value), 'h44);
        cyc();
        exp_edge("g3", 31, 1, 4);
        cyc();
        exp_none("g_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
